cic_interp: RTL and testbench
=============================

# cic_interp

Cascaded integrator-comb interpolator: accepts one signed input sample at the low rate, raises the rate by R and emits R filtered output samples per input. Structure is N comb stages at the input rate, a zero-stuffing upsampler, then N integrators at the output rate. It is the transmit-side counterpart of the decimating comb/integrator chain and sits between a baseband sample source and a high-rate consumer. The block uses valid/ready flow control on both sides.

## Interface
- IW, 8, input sample width (signed two's complement)
- OW, 17, internal/full-precision width; must satisfy OW >= IW + N*ceil(log2(R*M))
- OTW, 17, output port width, OTW <= OW
- R, 8, interpolation ratio, >= 2
- N, 3, number of comb stages and number of integrator stages, >= 1
- M, 1, comb differential delay, >= 1
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_data  input  IW  signed input sample
- i_valid  input  1  i_data valid
- o_in_ready  output  1  block accepts i_data this cycle (combinational)
- o_data  output  OTW  signed output sample (registered)
- o_valid  output  1  o_data valid (registered)
- i_out_ready  input  1  consumer accepts o_data this cycle

## Operation
- accept = i_valid & o_in_ready. advance = h_valid & (!o_valid | i_out_ready).
- Comb section, all stages OW wide, updated only on accept: c0 = sign-extended i_data; ck = c(k-1) - c(k-1) delayed M accepts; M-deep delay line per stage. cN is captured into holding register h, and h_valid is set.
- Upsampler: phase counter cnt, 0..R-1. Integrator input x = h when cnt==0, else 0. Each advance increments cnt, wrapping R-1 -> 0.
- Integrators, combinational next values: y1 = I1 + x; yk = Ik + y(k-1). On advance all Ik <= yk and o_data <= out(yN). o_valid <= 1.
- If o_valid & i_out_ready & !advance, then o_valid <= 0.
- h_valid clears on an advance with cnt==R-1, unless accept occurs in the same cycle.
- o_in_ready = !h_valid | (advance & cnt==R-1).
- Simultaneous last-phase advance and accept: h is reloaded and cnt wraps to 0. The next advance uses the new h, so there is no bubble.
- All arithmetic is modular two's complement at OW bits. Wrap-around is intentional and cancels across the CIC; no saturation.
- Steady-state DC gain = (R*M)^N / R.

## Timing
- Reset (asynchronous, any time including mid-burst) clears all comb delay lines, h, h_valid, cnt, integrators, o_data and o_valid to 0. o_in_ready = 1 while in reset and on the first cycle after.
- Latency: the first output for an accepted sample is valid on the cycle after accept, when the output slot is free. That output is emitted with o_valid high the following cycle.
- Each accepted sample yields exactly R advances.
- With i_valid and i_out_ready held high, o_valid is continuously 1 and o_in_ready is high 1 cycle in every R.
- While o_valid & !i_out_ready: o_data, o_valid, cnt and integrators are frozen, and o_in_ready = 0 if h_valid.
- When the source starves (h_valid=0): no advance occurs, o_valid drops after the last output is consumed, and integrator state is retained.

## Configuration
- CIC_INTERP_ROUND_EN defined: out(y) = (y + 2^(OW-OTW-1)) >> (OW-OTW), keeping the low OTW bits (round half up, wraps).
- CIC_INTERP_ROUND_EN undefined: out(y) = y >> (OW-OTW), i.e. truncation.
- When OTW == OW, both modes yield y unchanged.

## Test plan
- Reset asserted mid-burst -> o_valid=0, o_data=0, o_in_ready=1 immediately. After release, an impulse reproduces the first-run response exactly.
- N=1, M=1, R=4, input 5 then 0s, i_out_ready=1 -> outputs 5,5,5,5,0,0,0,0.
- Defaults, input 1 held, i_out_ready=1 -> first outputs 1,3,6,10,15,21,28,36; outputs 22 onward are constant 64.
- Defaults, i_out_ready low for 3 cycles mid-burst -> o_data/o_valid stable, cnt frozen, o_in_ready=0. After release, the sequence continues with no gap or duplicate.
- i_valid held, i_out_ready=1, R=8 -> o_in_ready high exactly 1 of every 8 cycles, o_valid never drops after the first output.
- N=1, R=4, M=1, OW=12, OTW=10, input 7 held -> steady output 2 with CIC_INTERP_ROUND_EN, 1 without.

Source files
------------

// File: rtl/cic_interp.sv
// rtl/cic_interp.sv - CIC interpolator: N combs at input rate, zero-stuff by R, N integrators at output rate.
// Define CIC_INTERP_ROUND_EN to round (half up) instead of truncate when OTW < OW.
module cic_interp #(
  parameter int IW  = 8,
  parameter int OW  = 17,
  parameter int OTW = 17,
  parameter int R   = 8,
  parameter int N   = 3,
  parameter int M   = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [IW-1:0]  i_data,
  input  logic           i_valid,
  output logic           o_in_ready,
  output logic [OTW-1:0] o_data,
  output logic           o_valid,
  input  logic           i_out_ready
);

  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam int SH = OW - OTW;
  localparam logic [CW-1:0] LAST = CW'(R - 1);
`ifdef CIC_INTERP_ROUND_EN
  localparam int RSH = (SH > 0) ? SH - 1 : 0;
`endif

  logic [OW-1:0]  dly_q [N][M];
  logic [OW-1:0]  c [N+1];
  logic [OW-1:0]  h_q;
  logic           h_valid_q, h_valid_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [OW-1:0]  integ_q [N];
  logic [OW-1:0]  y [N];
  logic [OW-1:0]  x;
  logic [OTW-1:0] o_data_q;
  logic           o_valid_q, o_valid_d;
  logic           accept, advance, last_phase;

  function automatic logic [OTW-1:0] scale(input logic [OW-1:0] y_in);
    logic [OW-1:0] t;
`ifdef CIC_INTERP_ROUND_EN
    t = (SH > 0) ? y_in + (OW'(1) << RSH) : y_in;
`else
    t = y_in;
`endif
    return OTW'(t >> SH);
  endfunction

  always_comb begin
    advance    = h_valid_q & (~o_valid_q | i_out_ready);
    last_phase = (cnt_q == LAST);
    o_in_ready = ~h_valid_q | (advance & last_phase);
    accept     = i_valid & o_in_ready;
  end

  // Comb chain: each stage subtracts its input from M accepts ago.
  always_comb begin
    c[0] = OW'($signed(i_data));
    for (int k = 0; k < N; k++) begin
      c[k+1] = c[k] - dly_q[k][M-1];
    end
  end

  always_comb begin
    x    = (cnt_q == '0) ? h_q : '0;
    y[0] = integ_q[0] + x;
    for (int k = 1; k < N; k++) begin
      y[k] = integ_q[k] + y[k-1];
    end
  end

  // A last-phase advance with a same-cycle accept keeps h_valid set, so no bubble.
  always_comb begin
    cnt_d     = cnt_q;
    h_valid_d = h_valid_q;
    o_valid_d = o_valid_q;
    if (advance) begin
      cnt_d     = last_phase ? '0 : cnt_q + 1'b1;
      o_valid_d = 1'b1;
      if (last_phase) begin
        h_valid_d = 1'b0;
      end
    end else if (o_valid_q & i_out_ready) begin
      o_valid_d = 1'b0;
    end
    if (accept) begin
      h_valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N; k++) begin
        for (int j = 0; j < M; j++) begin
          dly_q[k][j] <= '0;
        end
        integ_q[k] <= '0;
      end
      h_q       <= '0;
      h_valid_q <= 1'b0;
      cnt_q     <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      h_valid_q <= h_valid_d;
      o_valid_q <= o_valid_d;
      if (accept) begin
        h_q <= c[N];
        for (int k = 0; k < N; k++) begin
          dly_q[k][0] <= c[k];
          for (int j = 1; j < M; j++) begin
            dly_q[k][j] <= dly_q[k][j-1];
          end
        end
      end
      if (advance) begin
        for (int k = 0; k < N; k++) begin
          integ_q[k] <= y[k];
        end
        o_data_q <= scale(y[N-1]);
      end
    end
  end

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_cic_interp.sv
// tb/tb_cic_interp.sv - directed bench for cic_interp against a convolution model of the CIC response.
module tb_cic_interp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_in_ready;
  logic [16:0] o_data;
  logic        o_valid;
  logic        i_out_ready;

  logic        rst2_n;
  logic [7:0]  s2_data, s3_data;
  logic        s2_valid, s3_valid, s2_rdy, s3_rdy;
  logic [9:0]  o2_data, o3_data;
  logic        o2_valid, o3_valid;

  cic_interp #(.IW(8), .OW(17), .OTW(17), .R(8), .N(3), .M(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_in_ready(o_in_ready), .o_data(o_data), .o_valid(o_valid), .i_out_ready(i_out_ready));

  cic_interp #(.IW(8), .OW(12), .OTW(10), .R(4), .N(1), .M(1)) dut2 (
    .i_clk(clk), .i_rst_n(rst2_n), .i_data(s2_data), .i_valid(s2_valid),
    .o_in_ready(s2_rdy), .o_data(o2_data), .o_valid(o2_valid), .i_out_ready(1'b1));

  cic_interp #(.IW(8), .OW(10), .OTW(10), .R(4), .N(1), .M(1)) dut3 (
    .i_clk(clk), .i_rst_n(rst2_n), .i_data(s3_data), .i_valid(s3_valid),
    .o_in_ready(s3_rdy), .o_data(o3_data), .o_valid(o3_valid), .i_out_ready(1'b1));

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint wrap(input longint v, input int w);
    longint mask;
    longint r;
    mask = (longint'(1) << w) - 1;
    r = v & mask;
    if (r[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  // Output n = sum of accepted samples times the ((1-z^-RM)/(1-z^-1))^N taps, then scaled.
  function automatic int cic_model(input int q[$], input int n, input int r, input int ns,
                                   input int m, input int ow, input int otw);
    longint g[$];
    longint t[$];
    longint acc;
    int sh;
    g = {1};
    for (int s = 0; s < ns; s++) begin
      t = {};
      for (int i = 0; i < g.size() + r * m - 1; i++) begin
        acc = 0;
        for (int j = 0; j < r * m; j++)
          if (i - j >= 0 && i - j < g.size()) acc += g[i-j];
        t.push_back(acc);
      end
      g = t;
    end
    acc = 0;
    for (int k = 0; k < q.size(); k++)
      if (r * k <= n && n - r * k < g.size()) acc += longint'(q[k]) * g[n - r * k];
    acc = wrap(acc, ow);
    sh = ow - otw;
`ifdef CIC_INTERP_ROUND_EN
    if (sh > 0) acc += longint'(1) <<< (sh - 1);
`endif
    acc = acc >>> sh;
    return int'(wrap(acc, otw));
  endfunction

  int acc_q[$];
  int src[$];
  int sidx = 0;
  bit en_src = 0;
  int oidx = 0;
  int log_a[256];
  int cyc = 0;
  int first_acc = -1, first_val = -1;
  bit prev_v = 0, prev_rdy = 0;
  logic [16:0] prev_d;
  bit win_en = 0;
  int win_rdy = 0, win_drop = 0;
  bit done2 = 0;

  initial begin
    i_valid = 0;
    i_data  = 0;
    forever begin
      @(negedge clk);
      if (en_src && sidx < src.size()) begin
        i_valid = 1;
        i_data  = 8'(src[sidx]);
      end else begin
        i_valid = 0;
        i_data  = 0;
      end
    end
  end

  initial begin
    int sd;
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (!rst_n) begin
        prev_v = 0;
      end else begin
        if (i_valid && o_in_ready) begin
          acc_q.push_back(int'($signed(i_data)));
          sidx++;
          if (first_acc < 0) first_acc = cyc;
        end
        sd = int'($signed(o_data));
        if (prev_v && !prev_rdy) begin
          chk("hold_valid", int'(o_valid), 1);
          chk("hold_data", sd, int'($signed(prev_d)));
        end
        if (o_valid && first_val < 0 && first_acc >= 0) begin
          first_val = cyc;
          chk("latency", first_val - first_acc, 2);
        end
        if (win_en) begin
          if (o_in_ready) win_rdy++;
          if (!o_valid) win_drop++;
        end
        if (o_valid && i_out_ready) begin
          chk($sformatf("out[%0d]", oidx), sd, cic_model(acc_q, oidx, 8, 3, 1, 17, 17));
          if (oidx < 256) log_a[oidx] = sd;
          oidx++;
        end
        prev_v   = o_valid;
        prev_rdy = i_out_ready;
        prev_d   = o_data;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    en_src = 0;
    i_out_ready = 1;
    rst_n = 0;
    #1;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_in_ready", int'(o_in_ready), 1);
    acc_q = {};
    src = {};
    sidx = 0;
    oidx = 0;
    first_acc = -1;
    first_val = -1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    #1;
    chk("in_ready_after_rst", int'(o_in_ready), 1);
  endtask

  task automatic wait_out(input int n, input int lim);
    int c = 0;
    while (oidx < n && c < lim) begin
      @(posedge clk);
      c++;
    end
    chk($sformatf("reached_%0d_outputs", n), (oidx >= n) ? 1 : 0, 1);
  endtask

  task automatic chk_impulse(input string tag);
    int e[11] = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48};
    for (int i = 0; i < 11; i++) chk($sformatf("%s_lit[%0d]", tag, i), log_a[i], e[i]);
    chk({tag, "_lit[21]"}, log_a[21], 1);
    chk({tag, "_lit[22]"}, log_a[22], 0);
  endtask

  initial begin
    logic [15:0] pat;
    int c;
    rst_n = 0;
    i_out_ready = 1;
    pat = 16'b1011_0010_1110_0101;

    do_reset();
    src = {1, 0, 0, 0};
    en_src = 1;
    wait_out(32, 400);
    chk_impulse("impulse1");
    repeat (4) @(posedge clk);
    #3;
    chk("starve_valid", int'(o_valid), 0);
    chk("starve_in_ready", int'(o_in_ready), 1);

    do_reset();
    for (int i = 0; i < 40; i++) src.push_back(1);
    en_src = 1;
    wait_out(24, 400);
    begin
      int e[8] = '{1, 3, 6, 10, 15, 21, 28, 36};
      for (int i = 0; i < 8; i++) chk($sformatf("step_lit[%0d]", i), log_a[i], e[i]);
    end
    chk("step_lit[21]", log_a[21], 64);
    chk("step_lit[23]", log_a[23], 64);
    win_rdy = 0;
    win_drop = 0;
    @(posedge clk);
    #2;
    win_en = 1;
    repeat (80) @(posedge clk);
    #2;
    win_en = 0;
    chk("in_ready_1_in_8", win_rdy, 10);
    chk("valid_never_drops", win_drop, 0);

    do_reset();
    src = {1, 0, 0, 0};
    en_src = 1;
    wait_out(32, 400);
    chk_impulse("impulse2");

    do_reset();
    src = {3, -2, 7, -8, 127, -128, 0, 5, -1, 64};
    en_src = 1;
    wait_out(20, 400);
    @(posedge clk);
    #2;
    i_out_ready = 0;
    #1;
    chk("stall_in_ready0", int'(o_in_ready), 0);
    for (int i = 1; i < 3; i++) begin
      @(posedge clk);
      #3;
      chk($sformatf("stall_in_ready%0d", i), int'(o_in_ready), 0);
    end
    @(posedge clk);
    #2;
    i_out_ready = 1;
    wait_out(80, 800);

    do_reset();
    for (int i = 0; i < 16; i++) src.push_back((i % 2) ? -128 : 127);
    en_src = 1;
    c = 0;
    while (oidx < 128 && c < 2000) begin
      @(posedge clk);
      #2;
      i_out_ready = pat[c % 16];
      c++;
    end
    i_out_ready = 1;
    chk("pattern_outputs", (oidx >= 128) ? 1 : 0, 1);

    c = 0;
    while (!done2 && c < 500) begin
      @(posedge clk);
      c++;
    end
    chk("small_dut_done", int'(done2), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    int acc2[$];
    int acc3[$];
    int n2 = 0, n3 = 0;
    int log3[8];
    int exp3[8] = '{5, 5, 5, 5, 0, 0, 0, 0};
    int v2a = -99, v2b = -99;
    int st;
    int sd;
`ifdef CIC_INTERP_ROUND_EN
    st = 2;
`else
    st = 1;
`endif
    for (int i = 0; i < 8; i++) log3[i] = -99;
    rst2_n = 0;
    s2_valid = 0;
    s3_valid = 0;
    s2_data = 0;
    s3_data = 0;
    repeat (3) @(posedge clk);
    #2;
    rst2_n = 1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      s2_valid = 1;
      s2_data  = 8'd7;
      s3_valid = 1;
      s3_data  = (acc3.size() == 0) ? 8'd5 : 8'd0;
      #4;
      if (s2_rdy) acc2.push_back(7);
      if (s3_rdy) acc3.push_back(int'($signed(s3_data)));
      if (o2_valid) begin
        sd = int'($signed(o2_data));
        chk($sformatf("scaled_out[%0d]", n2), sd, cic_model(acc2, n2, 4, 1, 1, 12, 10));
        if (n2 == 10) v2a = sd;
        if (n2 == 30) v2b = sd;
        n2++;
      end
      if (o3_valid) begin
        sd = int'($signed(o3_data));
        chk($sformatf("n1_out[%0d]", n3), sd, cic_model(acc3, n3, 4, 1, 1, 10, 10));
        if (n3 < 8) log3[n3] = sd;
        n3++;
      end
    end
    for (int i = 0; i < 8; i++) chk($sformatf("n1_lit[%0d]", i), log3[i], exp3[i]);
    chk("scaled_steady_a", v2a, st);
    chk("scaled_steady_b", v2b, st);
    done2 = 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", err_cnt);
    $fatal(1);
  end

endmodule
